muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//   Iterative multiply/divide sequencer that owns the HI/LO register pair for the
//   MIPS single-cycle core. Accepts mult/multu/div/divu and runs a WIDTH-step
//   shift-add or restoring-divide loop. Holds busy while it works and raises a
//   stall to the core if the core touches HI/LO before the result is ready.
//   Also services mthi/mtlo writes and feeds the mfhi/mflo read path.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are each WIDTH bits
// PORTS
//   clk      in   1      core clock
//   reset    in   1      synchronous, active-low reset (0 = reset)
//   start    in   1      launch op with a/b this cycle
//   op       in   2      00 mult, 01 multu, 10 div, 11 divu
//   a        in   WIDTH  rs operand: multiplicand or dividend
//   b        in   WIDTH  rt operand: multiplier or divisor
//   rd_hilo  in   1      core executes mfhi/mflo this cycle
//   wr_hi    in   1      mthi: hi <= wdata
//   wr_lo    in   1      mtlo: lo <= wdata
//   wdata    in   WIDTH  mthi/mtlo data
//   hi       out  WIDTH  HI register (product[2W-1:W] / remainder)
//   lo       out  WIDTH  LO register (product[W-1:0] / quotient)
//   busy     out  1      operation in flight (state != IDLE)
//   stall    out  1      busy & (start | rd_hilo | wr_hi | wr_lo)
//   done     out  1      one-cycle pulse: hi/lo just updated (or div-by-0)
//   divzero  out  1      one-cycle pulse with done: div/divu with b==0
// BEHAVIOUR
//   Reset (reset==0 at posedge): state=IDLE, hi=lo=0, all work regs cleared,
//     busy=stall=done=divzero=0. Applies mid-operation: the in-flight op is
//     abandoned and no done is issued.
//   FSM states: IDLE -> PREP -> CALC -> FIX -> IDLE.
//   IDLE: start=1 latches op and a/b, then goes to PREP. start has priority over
//     wr_hi/wr_lo in the same cycle; the write is dropped. Otherwise wr_hi and
//     wr_lo update hi/lo at the edge (both may be written in one cycle).
//   PREP: signed ops convert operands to magnitude and record the result sign(s).
//     div/divu with b==0 skips to IDLE: hi/lo unchanged, done=divzero=1 for the
//     next cycle. Otherwise load counter=WIDTH-1 and go to CALC.
//   CALC: one shift-add (mul) or shift-subtract-restore (div) step per cycle.
//     Counter decrements and leaves for FIX after the step at counter==0, giving
//     exactly WIDTH steps.
//   FIX: apply the sign. mult: negate the 2W product if the signs differ.
//     div: quotient is negated if the signs differ (truncation toward zero);
//     remainder takes the sign of the dividend. Write hi/lo, go to IDLE,
//     done=1 next cycle.
//   Latency: start sampled at edge k. hi/lo are valid and done=1 in the cycle
//     after edge k+WIDTH+2 (34 edges for WIDTH=32). div-by-0 takes 2 edges.
//   div overflow (-2^(W-1) / -1) is not trapped: lo=0x80000000, hi=0.
//   While busy: start, wr_hi and wr_lo are ignored (not queued). The core holds
//     them under stall and re-presents them once busy falls.
//   hi/lo outputs hold their old value until the FIX write. rd_hilo only
//     affects stall and never the registers.
//   done/divzero are registered pulses, exactly one cycle wide. A new start may
//     be sampled in the same cycle that done is high.
// TESTING
//   multu a=7 b=6 -> done 34 cycles after start, lo=0x2A hi=0, busy high cycles 1..34
//   mult a=0xFFFFFFFD(-3) b=5 -> lo=0xFFFFFFF1 hi=0xFFFFFFFF
//   div a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; divu 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF hi=0xF
//   divu a=5 b=0 after mthi 0x11/mtlo 0x22 -> done=divzero=1 at cycle 2, hi=0x11 lo=0x22 kept
//   rd_hilo=1 and wr_lo=1 at cycle 5 of an op -> stall=1, lo unchanged; stall=0 once done
//   reset=0 at cycle 10 of a mult -> next cycle busy=0 hi=lo=0, no done pulse; new op runs clean

Source files
------------

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative multiply/divide sequencer owning the HI/LO pair.
//                WIDTH-step shift-add multiply and restoring divide, with
//                stall generation and mthi/mtlo write service.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hilo,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             divzero
);

    localparam int c_CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_p;       // {hi half, lo half} working register
    logic [WIDTH-1:0]     r_d;       // multiplicand or divisor magnitude
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_neg_res; // product / quotient must be negated
    logic                 r_neg_rem; // remainder must be negated
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_divzero;

    // Operation decode and operand magnitudes (op[0]=1 means unsigned)
    logic             w_is_div;
    logic             w_signed;
    logic             w_div0;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];
    assign w_div0   = w_is_div && (r_b == '0);
    assign w_a_mag  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_b_mag  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

    // Multiply step: conditionally add multiplicand to upper half, shift right
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;

    assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_d} : '0);
    assign w_mul_step = {w_mul_sum, r_p[WIDTH-1:1]};

    // Divide step: shift partial remainder left, trial subtract, restore if negative
    logic [WIDTH:0]     w_div_rem;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_step;

    assign w_div_rem  = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_div_diff = w_div_rem - {1'b0, r_d};
    assign w_div_ok   = ~w_div_diff[WIDTH];
    assign w_div_step = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_rem[WIDTH-1:0]),
                         r_p[WIDTH-2:0], w_div_ok};

    // Sign fix-up of the final magnitudes
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod = r_neg_res ? -r_p : r_p;
    assign w_quo  = r_neg_res ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_PREP;
            S_PREP:  w_state_nxt = w_div0 ? S_IDLE : S_CALC;
            S_CALC:  if (r_cnt == '0) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Working registers: operand latch, magnitude prep and per-cycle step
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_p       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
                    end
                end
                S_PREP: begin
                    r_neg_res <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_rem <= w_signed & r_a[WIDTH-1];
                    r_cnt     <= c_CNT_W'(WIDTH - 1);
                    if (w_is_div) begin
                        r_p <= {{WIDTH{1'b0}}, w_a_mag};
                        r_d <= w_b_mag;
                    end else begin
                        r_p <= {{WIDTH{1'b0}}, w_b_mag};
                        r_d <= w_a_mag;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_p   <= w_is_div ? w_div_step : w_mul_step;
                end
                default: ;
            endcase
        end
    end

    // HI/LO architectural registers and registered completion pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start in the same cycle wins; the move-to write is dropped
                    if (!start) begin
                        if (wr_hi) r_hi <= wdata;
                        if (wr_lo) r_lo <= wdata;
                    end
                end
                S_PREP: begin
                    if (w_div0) begin
                        r_done    <= 1'b1;
                        r_divzero <= 1'b1;
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (w_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign busy    = (r_state != S_IDLE);
    assign stall   = busy & (start | rd_hilo | wr_hi | wr_lo);
    assign done    = r_done;
    assign divzero = r_divzero;

endmodule
`default_nettype wire
